// File: rtl/fwrisc_trace_ctrl.sv
// Trigger/capture controller for the fwrisc retirement trace: arms on request, starts on a PC
// match, buffers retired-instruction events in a FIFO and streams them out over valid/ready.
module fwrisc_trace_ctrl #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic [31:0]              instr,
    input  logic                     ivalid,
    input  logic                     trap,
    input  logic                     tret,
    input  logic                     rd_write,
    input  logic [31:0]              rd_wdata,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    input  logic [CNT_W-1:0]         post_count,
    output logic                     t_valid,
    input  logic                     t_ready,
    output logic [31:0]              t_pc,
    output logic [31:0]              t_instr,
    output logic [31:0]              t_wdata,
    output logic [3:0]               t_flags,
    output logic [1:0]               state,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] wdata;
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    state_e           state_q, state_d;
    logic             trig_en_q, trig_en_d;
    logic [31:0]      trig_pc_q, trig_pc_d;
    logic [CNT_W-1:0] post_q, post_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             tvalid_q, tvalid_d;
    entry_t           head_q, head_d;
    entry_t           mem_q [DEPTH];

    logic             hit;
    logic             full;
    logic             pop;
    logic             push_req;
    logic             push_trig;
    logic             push_ok;
    entry_t           push_ent;

    always_comb begin
        state_d   = state_q;
        trig_en_d = trig_en_q;
        trig_pc_d = trig_pc_q;
        post_d    = post_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        push_req  = 1'b0;
        push_trig = 1'b0;
        hit       = ivalid && (!trig_en_q || (pc == trig_pc_q));
        full      = (level_q == LW'(DEPTH));
        pop       = tvalid_q && t_ready;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d   = S_ARMED;
                    trig_en_d = trig_en;
                    trig_pc_d = trig_pc;
                    post_d    = post_count;
                    ovf_d     = 1'b0;
                end
            end
            S_ARMED: begin
                if (hit) begin
                    push_req  = 1'b1;
                    push_trig = 1'b1;
                    cnt_d     = post_q - 1'b1;
                    state_d   = (post_q == CNT_W'(1)) ? S_DRAIN : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // post_q == 0 means unbounded capture; the counter is left alone
                if (ivalid) begin
                    push_req = 1'b1;
                    if (post_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (level_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A full FIFO still accepts the event when the head leaves in the same cycle
        push_ok = push_req && (!full || pop);
        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end

        push_ent.pc    = pc;
        push_ent.instr = instr;
        push_ent.wdata = rd_write ? rd_wdata : 32'd0;
        push_ent.flags = {push_trig, trap, tret, rd_write};

        wr_ptr_d = push_ok ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + 1'b1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop);

        // Output stage reloads from entries already stored, giving one cycle of latency
        tvalid_d = ((level_q - LW'(pop)) != '0);
        head_d   = head_q;
        if (tvalid_d) begin
            head_d = mem_q[rd_ptr_d];
        end

        if (abort) begin
            state_d   = S_IDLE;
            trig_en_d = trig_en_q;
            trig_pc_d = trig_pc_q;
            post_d    = post_q;
            cnt_d     = cnt_q;
            ovf_d     = ovf_q;
            push_ok   = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            tvalid_d  = 1'b0;
            head_d    = head_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            trig_en_q <= 1'b0;
            trig_pc_q <= '0;
            post_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            tvalid_q  <= 1'b0;
            head_q    <= '0;
        end else begin
            state_q   <= state_d;
            trig_en_q <= trig_en_d;
            trig_pc_q <= trig_pc_d;
            post_q    <= post_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            tvalid_q  <= tvalid_d;
            head_q    <= head_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

    assign t_valid  = tvalid_q;
    assign t_pc     = head_q.pc;
    assign t_instr  = head_q.instr;
    assign t_wdata  = head_q.wdata;
    assign t_flags  = head_q.flags;
    assign state    = state_q;
    assign overflow = ovf_q;
    assign level    = level_q;

endmodule

// File: tb/tb_fwrisc_trace_ctrl.sv
// Bench for fwrisc_trace_ctrl: directed scenarios plus random traffic against a queue-based
// reference of the capture/stream behaviour.
module tb_fwrisc_trace_ctrl;

    localparam int DEPTH = 16;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    localparam int M_IDLE    = 0;
    localparam int M_ARMED   = 1;
    localparam int M_CAPTURE = 2;
    localparam int M_DRAIN   = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic [31:0]      pc, instr, rd_wdata, trig_pc;
    logic             ivalid, trap, tret, rd_write, arm, abort, trig_en, t_ready;
    logic [CNT_W-1:0] post_count;
    logic             t_valid, overflow;
    logic [31:0]      t_pc, t_instr, t_wdata;
    logic [3:0]       t_flags;
    logic [1:0]       state;
    logic [LW-1:0]    level;

    fwrisc_trace_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .pc(pc), .instr(instr), .ivalid(ivalid),
        .trap(trap), .tret(tret), .rd_write(rd_write), .rd_wdata(rd_wdata),
        .arm(arm), .abort(abort), .trig_en(trig_en), .trig_pc(trig_pc),
        .post_count(post_count), .t_valid(t_valid), .t_ready(t_ready), .t_pc(t_pc),
        .t_instr(t_instr), .t_wdata(t_wdata), .t_flags(t_flags), .state(state),
        .overflow(overflow), .level(level)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
        logic [3:0]  flags;
    } ent_t;

    ent_t        mq[$];
    int          m_ph;
    bit          m_ten;
    logic [31:0] m_tpc;
    int          m_pcnt;
    int          m_taken;
    bit          m_ovf;
    bit          m_tvalid;

    int          n_assert;
    int          n_fail;
    int          dut_pops;
    logic [31:0] popped_pc[$];
    int          d0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ph     = M_IDLE;
        m_ovf    = 1'b0;
        m_tvalid = 1'b0;
        m_taken  = 0;
    endtask

    task automatic chk_reset_outputs(input string tg);
        chk({tg, "_state"},   64'(state),    64'(0));
        chk({tg, "_level"},   64'(level),    64'(0));
        chk({tg, "_tvalid"},  64'(t_valid),  64'(0));
        chk({tg, "_tpc"},     64'(t_pc),     64'(0));
        chk({tg, "_tinstr"},  64'(t_instr),  64'(0));
        chk({tg, "_twdata"},  64'(t_wdata),  64'(0));
        chk({tg, "_tflags"},  64'(t_flags),  64'(0));
        chk({tg, "_ovf"},     64'(overflow), 64'(0));
    endtask

    // One clock: advance the reference with the current inputs, clock the DUT, compare.
    task automatic tick();
        int   lvl0;
        bit   pop;
        bit   attempt;
        bit   trig;
        ent_t e;
        lvl0    = mq.size();
        pop     = m_tvalid && t_ready;
        attempt = 1'b0;
        trig    = 1'b0;
        if (t_valid && t_ready) begin
            dut_pops++;
            popped_pc.push_back(t_pc);
        end
        if (abort) begin
            mq.delete();
            m_ph     = M_IDLE;
            m_tvalid = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            case (m_ph)
                M_IDLE: if (arm) begin
                    m_ph   = M_ARMED;
                    m_ten  = trig_en;
                    m_tpc  = trig_pc;
                    m_pcnt = int'(post_count);
                    m_ovf  = 1'b0;
                end
                M_ARMED: if (ivalid && (!m_ten || pc == m_tpc)) begin
                    attempt = 1'b1;
                    trig    = 1'b1;
                    m_taken = 1;
                    m_ph    = (m_pcnt == 1) ? M_DRAIN : M_CAPTURE;
                end
                M_CAPTURE: if (ivalid) begin
                    attempt = 1'b1;
                    m_taken++;
                    if (m_pcnt != 0 && m_taken >= m_pcnt) m_ph = M_DRAIN;
                end
                default: if (lvl0 == 0) m_ph = M_IDLE;
            endcase
            if (attempt) begin
                e.pc    = pc;
                e.instr = instr;
                e.wdata = rd_write ? rd_wdata : 32'd0;
                e.flags = {trig, trap, tret, rd_write};
                if (lvl0 < DEPTH || pop) mq.push_back(e);
                else m_ovf = 1'b1;
            end
            m_tvalid = (lvl0 - int'(pop)) > 0;
        end
        @(posedge clock);
        @(negedge clock);
        chk("state",    64'(state),    64'(m_ph));
        chk("level",    64'(level),    64'(mq.size()));
        chk("t_valid",  64'(t_valid),  64'(m_tvalid));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (m_tvalid && mq.size() > 0) begin
            chk("t_pc",    64'(t_pc),    64'(mq[0].pc));
            chk("t_instr", 64'(t_instr), 64'(mq[0].instr));
            chk("t_wdata", 64'(t_wdata), 64'(mq[0].wdata));
            chk("t_flags", 64'(t_flags), 64'(mq[0].flags));
        end
    endtask

    task automatic ev(input logic [31:0] p);
        ivalid   = 1'b1;
        pc       = p;
        instr    = $urandom;
        trap     = 1'($urandom_range(0, 1));
        tret     = 1'($urandom_range(0, 1));
        rd_write = 1'($urandom_range(0, 1));
        rd_wdata = $urandom;
        tick();
        ivalid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_arm(input bit ten, input logic [31:0] tpc, input int pcnt);
        arm        = 1'b1;
        trig_en    = ten;
        trig_pc    = tpc;
        post_count = CNT_W'(pcnt);
        tick();
        arm        = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic drain_to_idle();
        for (int i = 0; i < 200 && m_ph != M_IDLE; i++) tick();
        chk("drain_idle", 64'(state), 64'(M_IDLE));
    endtask

    initial begin
        n_assert = 0; n_fail = 0; dut_pops = 0;
        pc = '0; instr = '0; rd_wdata = '0; trig_pc = '0; post_count = '0;
        ivalid = 0; trap = 0; tret = 0; rd_write = 0; arm = 0; abort = 0;
        trig_en = 0; t_ready = 0;
        model_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 chk_reset_outputs("rst0");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        idle(2);

        // Free-running trigger, three events captured, latency of one extra cycle
        t_ready = 1'b1;
        d0 = dut_pops;
        pulse_arm(1'b0, 32'd0, 3);
        chk("t1_armed", 64'(state), 64'(M_ARMED));
        ev($urandom);
        chk("t1_lat0", 64'(t_valid), 64'(0));
        ev($urandom);
        chk("t1_lat1", 64'(t_valid), 64'(1));
        for (int i = 0; i < 3; i++) ev($urandom);
        drain_to_idle();
        chk("t1_count", 64'(dut_pops - d0), 64'(3));
        chk("t1_ovf", 64'(overflow), 64'(0));

        // PC-match trigger
        d0 = dut_pops;
        popped_pc.delete();
        pulse_arm(1'b1, 32'h8000_0010, 2);
        for (int i = 0; i < 9; i++) ev(32'h8000_0000 + 32'(4 * i));
        drain_to_idle();
        chk("t2_count", 64'(dut_pops - d0), 64'(2));
        chk("t2_pc0", 64'(popped_pc.size() > 0 ? popped_pc[0] : 32'd0), 64'h8000_0010);
        chk("t2_pc1", 64'(popped_pc.size() > 1 ? popped_pc[1] : 32'd0), 64'h8000_0014);

        // Overflow on a stalled host, then drain in order
        t_ready = 1'b0;
        pulse_arm(1'b0, 32'd0, 20);
        for (int i = 0; i < 20; i++) ev(32'h1000 + 32'(4 * i));
        chk("t3_level", 64'(level), 64'(16));
        chk("t3_ovf", 64'(overflow), 64'(1));
        chk("t3_drain", 64'(state), 64'(M_DRAIN));
        t_ready = 1'b1;
        d0 = dut_pops;
        drain_to_idle();
        chk("t3_count", 64'(dut_pops - d0), 64'(16));
        pulse_arm(1'b0, 32'd0, 1);
        chk("t3_ovf_clr", 64'(overflow), 64'(0));
        pulse_abort();

        // Push into a full FIFO while the head is popped
        t_ready = 1'b0;
        pulse_arm(1'b0, 32'd0, 0);
        for (int i = 0; i < 16; i++) ev(32'h2000 + 32'(4 * i));
        chk("t4_full", 64'(level), 64'(16));
        t_ready = 1'b1;
        ev(32'h0000_1234);
        chk("t4_level", 64'(level), 64'(16));
        chk("t4_ovf", 64'(overflow), 64'(0));
        idle(20);
        chk("t4_empty", 64'(level), 64'(0));
        pulse_abort();

        // Abort mid-capture, then asynchronous reset mid-drain
        t_ready = 1'b0;
        pulse_arm(1'b0, 32'd0, 0);
        for (int i = 0; i < 5; i++) ev($urandom);
        chk("t5_level5", 64'(level), 64'(5));
        pulse_abort();
        chk("t5_state", 64'(state), 64'(M_IDLE));
        chk("t5_level", 64'(level), 64'(0));
        chk("t5_tvalid", 64'(t_valid), 64'(0));
        pulse_arm(1'b0, 32'd0, 10);
        for (int i = 0; i < 10; i++) ev($urandom);
        t_ready = 1'b1;
        idle(3);
        chk("t5_middrain", 64'(state), 64'(M_DRAIN));
        #2 reset = 1'b0;
        #1 chk_reset_outputs("t5_async");
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        idle(1);

        // Unbounded capture
        t_ready = 1'b1;
        d0 = dut_pops;
        pulse_arm(1'b0, 32'd0, 0);
        for (int i = 0; i < 40; i++) ev($urandom);
        idle(3);
        chk("t6_count", 64'(dut_pops - d0), 64'(40));
        chk("t6_state", 64'(state), 64'(M_CAPTURE));
        pulse_abort();
        chk("t6_idle", 64'(state), 64'(M_IDLE));

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            arm        = ($urandom_range(0, 7) == 0);
            abort      = ($urandom_range(0, 63) == 0);
            trig_en    = 1'($urandom_range(0, 1));
            trig_pc    = 32'h100 + 32'(4 * $urandom_range(0, 3));
            post_count = CNT_W'($urandom_range(0, 5));
            ivalid     = ($urandom_range(0, 2) != 0);
            pc         = 32'h100 + 32'(4 * $urandom_range(0, 3));
            instr      = $urandom;
            trap       = 1'($urandom_range(0, 1));
            tret       = 1'($urandom_range(0, 1));
            rd_write   = 1'($urandom_range(0, 1));
            rd_wdata   = $urandom;
            t_ready    = ($urandom_range(0, 3) != 0);
            tick();
        end
        arm = 0; ivalid = 0; abort = 0;
        pulse_abort();
        chk("rand_end", 64'(state), 64'(M_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
